// File: rtl/fifo_rd_pkg.sv
// Shared types and sizing helpers for the FIFO-mode read adapter.
// Default sizes match the memory core's FIFO-mode configuration.
package fifo_rd_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int RD_LATENCY_DEF = 1;
    localparam int SKID_DEPTH_DEF = 2;
    localparam int SKID_PTR_W     = (SKID_DEPTH_DEF > 1) ? $clog2(SKID_DEPTH_DEF) : 1;

    typedef struct packed {
        logic underflow;
        logic spurious;
    } rd_err_t;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Bits needed to hold the values 0..max_val inclusive.
    function automatic int count_width(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/fifo_read_adapter_skid.sv
// Skid buffer for words returned by the memory core: circular register array
// with read/write pointers and an occupancy count.
module rd_skid_buffer
    import fifo_rd_pkg::*;
#(
    parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter  int SKID_DEPTH = SKID_DEPTH_DEF,
    localparam int OCC_W      = count_width(SKID_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic [OCC_W-1:0]      occ,
    output logic                  full
);

    localparam int PTR_W = ptr_width(SKID_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [SKID_DEPTH];
    logic [PTR_W-1:0]      wptr_q, wptr_d;
    logic [PTR_W-1:0]      rptr_q, rptr_d;
    logic [OCC_W-1:0]      occ_q, occ_d;

    // Pointers wrap at SKID_DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(SKID_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        occ_d  = occ_q;
        if (clr) begin
            wptr_d = '0;
            rptr_d = '0;
            occ_d  = '0;
        end else begin
            if (push) begin
                mem_d[wptr_q] = push_data;
                wptr_d        = ptr_inc(wptr_q);
            end
            if (pop) begin
                rptr_d = ptr_inc(rptr_q);
            end
            occ_d = occ_q + OCC_W'(push) - OCC_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            occ_q  <= '0;
            for (int i = 0; i < SKID_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            occ_q  <= occ_d;
            mem_q  <= mem_d;
        end
    end

    assign head_data = mem_q[rptr_q];
    assign occ       = occ_q;
    assign full      = (occ_q == OCC_W'(SKID_DEPTH));

endmodule

// File: rtl/fifo_read_adapter.sv
// FIFO-mode read adapter: issues core reads, tracks them across the read
// latency, captures returns into a skid buffer and flags protocol errors.
module fifo_read_adapter
    import fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int RD_LATENCY = RD_LATENCY_DEF,
    parameter int SKID_DEPTH = SKID_DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk_en,
    input  logic                  flush,
    input  logic                  core_empty,
    input  logic                  core_valid,
    input  logic [DATA_WIDTH-1:0] core_data,
    output logic                  ren_out,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  err_underflow,
    output logic                  err_spurious
);

    localparam int OCC_W = count_width(SKID_DEPTH);
    localparam int CNT_W = count_width(RD_LATENCY);
    localparam int SUM_W = count_width(SKID_DEPTH + RD_LATENCY + 1);

    logic [RD_LATENCY-1:0] issued_q, issued_d;
    logic [CNT_W-1:0]      supp_q, supp_d;
    rd_err_t               err_q, err_d;

    logic [CNT_W-1:0] inflight;
    logic [OCC_W-1:0] occ;
    logic [SUM_W-1:0] committed;
    logic             buf_full;
    logic             ret;
    logic             pop;
    logic             push;
    logic             clr;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + CNT_W'(issued_q[i]);
        end
    end

    assign ret       = issued_q[RD_LATENCY-1];
    assign out_valid = (occ != '0);
    assign pop       = clk_en & out_valid & out_ready;
    assign push      = clk_en & ~flush & ret & core_valid;
    assign clr       = clk_en & flush;

    // Words buffered plus reads still in flight must leave room for one more;
    // a pop this cycle frees a slot early so streaming sustains full rate.
    assign committed = SUM_W'(occ) + SUM_W'(inflight);
    assign ren_out   = reset & clk_en & ~flush & ~core_empty &
                       (committed < (SUM_W'(SKID_DEPTH) + SUM_W'(pop)));

    always_comb begin
        issued_d = issued_q;
        supp_d   = supp_q;
        err_d    = err_q;
        if (clk_en) begin
            if (flush) begin
                issued_d = '0;
                supp_d   = CNT_W'(RD_LATENCY);
            end else begin
                issued_d = (issued_q << 1) | RD_LATENCY'(ren_out);
                if (supp_q != '0) begin
                    supp_d = supp_q - 1'b1;
                end
                if (ret && !core_valid) begin
                    err_d.underflow = 1'b1;
                end
                // Returns from reads cancelled by a flush land inside the
                // suppression window and are dropped without complaint.
                if (!ret && core_valid && (supp_q == '0)) begin
                    err_d.spurious = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            issued_q <= '0;
            supp_q   <= '0;
            err_q    <= '0;
        end else begin
            issued_q <= issued_d;
            supp_q   <= supp_d;
            err_q    <= err_d;
        end
    end

    assign err_underflow = err_q.underflow;
    assign err_spurious  = err_q.spurious;

    rd_skid_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .SKID_DEPTH (SKID_DEPTH)
    ) u_skid (
        .clk       (clk),
        .rst_n     (reset),
        .clr       (clr),
        .push      (push),
        .push_data (core_data),
        .pop       (pop),
        .head_data (out_data),
        .occ       (occ),
        .full      (buf_full)
    );

    always @(posedge clk) begin
        if (reset && push && !pop) begin
            assert (!buf_full);
        end
    end

endmodule

// File: doc/fifo_read_adapter.md
Name: fifo_read_adapter

Overview:
- Downstream neighbour of the memory core when the core runs in FIFO mode (mode=1, tile_en=1).
- Drives the core's ren_in and tracks reads in flight across the fixed read latency. It captures data_out on valid_out into a small skid buffer.
- Presents the captured words as a ready/valid stream to the consumer (A-QED checker or fabric).
- Flags protocol violations: a read with no returned data, or returned data with no read outstanding.

Parameters:
- DATA_WIDTH, 16, width of the data word.
- RD_LATENCY, 1, cycles from ren_out high to core_valid high for that read (range 1..4).
- SKID_DEPTH, 2, skid buffer entries. Must be >= RD_LATENCY+1 so streaming runs at full rate.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- clk_en  in  1  global clock enable; when low, all state holds and ren_out=0
- flush  in  1  synchronous flush of the buffer and the in-flight pipeline
- core_empty  in  1  memory core empty flag
- core_valid  in  1  memory core valid_out
- core_data  in  DATA_WIDTH  memory core data_out
- ren_out  out  1  read enable to memory core ren_in
- out_data  out  DATA_WIDTH  head-of-buffer word
- out_valid  out  1  buffer non-empty
- out_ready  in  1  consumer accepts out_data this cycle
- err_underflow  out  1  sticky: an issued read returned no data
- err_spurious  out  1  sticky: core_valid arrived with no read outstanding

Behaviour:
- Reset (reset=0, async):
  - ren_out=0, out_valid=0, out_data=0, err_underflow=0, err_spurious=0.
  - Buffer pointers, occupancy, in-flight shift register and in-flight count all cleared.
- Issue rule (combinational):
  - ren_out = clk_en & !flush & !core_empty & (occ + inflight - pop < SKID_DEPTH).
  - pop = out_valid & out_ready. A pop in the same cycle frees a slot.
- In-flight tracking:
  - RD_LATENCY-bit shift register issued[]; issued[0] <= ren_out each enabled cycle.
  - ret = issued[RD_LATENCY-1].
  - inflight = popcount(issued). It is never larger than RD_LATENCY.
- Capture:
  - When ret & core_valid, write core_data at the write pointer, then wptr++.
  - When ret & !core_valid, write nothing and set err_underflow.
  - When !ret & core_valid, drop the data and set err_spurious.
- Output:
  - out_data = buf[rptr]; out_valid = (occ != 0).
  - On pop, rptr++. out_data is 0-filled only after reset.
- Pointers wrap modulo SKID_DEPTH.
- Occupancy update:
  - occ_next = occ + capture - pop.
  - Simultaneous capture and pop with occ=SKID_DEPTH is legal: a pop frees the slot first.
  - A capture into a full buffer with no pop cannot occur by the issue rule. The checker asserts it.
- Throughput: with core non-empty and out_ready=1, one word per cycle in steady state.
- Latency: from ren_out to out_valid is RD_LATENCY+1 cycles (registered capture).
- flush=1 (requires clk_en=1):
  - Next edge clears the buffer, occ and issued[].
  - ren_out is forced to 0 that cycle.
  - Data returning after the flush from pre-flush reads is discarded silently and does not set err_spurious. A RD_LATENCY-cycle suppression counter handles this.
  - Sticky errors are not cleared by flush.
- clk_en=0: no state change, ren_out=0, and core_valid is ignored. Pop is also ignored, so the consumer must hold.
- Reset mid-operation: everything clears immediately. In-flight core returns after reset deassertion count as spurious. Integration holds the core in reset together with this block.

Decomposition:
- Package fifo_rd_pkg: DATA_WIDTH default, a localparam for the pointer width $clog2(SKID_DEPTH), and a struct for the error flags.
- One natural sub-module: rd_skid_buffer. It holds the SKID_DEPTH register array, pointers and occ, with push/pop/full/occ ports.
- Issue logic, in-flight tracking and error flags stay in the top module.

Test Plan:
- Stream: core preloaded with 0x0001..0x0008, out_ready=1 always -> ren_out high for 8 cycles. out_data gives 0x0001..0x0008 in order on consecutive cycles, first at cycle RD_LATENCY+1 after the first ren_out. No errors.
- Backpressure: 8 words, out_ready=0 from cycle 3 to cycle 10 -> occ saturates at 2 and ren_out drops to 0. No word is lost or duplicated; the order 0x0001..0x0008 is preserved after release.
- Empty gating: core_empty=1 with out_ready=1 -> ren_out stays 0 and out_valid stays 0 for 20 cycles.
- Underflow: force core_valid=0 on the return cycle of one issued read -> err_underflow=1 and stays 1. The captured-word count is reduced by 1.
- Spurious and flush: pulse core_valid with data 0xBEEF and no read issued -> err_spurious=1. Then pulse flush with 2 words buffered -> out_valid=0 next cycle, and a late return within RD_LATENCY does not change the err flags.
- Reset mid-stream: assert reset=0 asynchronously mid-burst -> all outputs go to 0 immediately without waiting for a clock edge. After release the block resumes issuing from the core head.
